// File: rtl/huffman_phase_ctrl_if.sv
// huffman_phase_ctrl_if
// Handshake bundle between the Huffman phase sequencer and its neighbours
// (host register block and the count/tree/code/encode datapath blocks).
//   master : the sequencer. It takes go/clear and the per-phase done inputs,
//            and drives the enables, start strobes and status.
//   slave  : host plus datapath side, the mirror image of master.
// clk and reset are not part of the bundle; they stay plain module ports.
interface huffman_phase_ctrl_if;
    // host / datapath -> sequencer
    logic        go;
    logic        clear;
    logic        count_done;
    logic [15:0] count_size;
    logic        tree_done;
    logic        code_done;
    logic        enc_done;
    // sequencer -> host / datapath
    logic        count_en;
    logic        tree_start;
    logic        code_start;
    logic        enc_start;
    logic        busy;
    logic        done;
    logic        empty;
    logic        err;
    logic [1:0]  err_code;
    logic [2:0]  state;
    logic [31:0] perf_cycles;

    modport master (
        input  go, clear, count_done, count_size, tree_done, code_done, enc_done,
        output count_en, tree_start, code_start, enc_start, busy, done, empty,
               err, err_code, state, perf_cycles
    );

    modport slave (
        output go, clear, count_done, count_size, tree_done, code_done, enc_done,
        input  count_en, tree_start, code_start, enc_start, busy, done, empty,
               err, err_code, state, perf_cycles
    );
endinterface

// File: rtl/huffman_phase_ctrl.sv
// huffman_phase_ctrl
// Top-level sequencer for the Huffman encoder. It steps through the phases
// COUNT -> TREE -> CODE -> ENCODE -> DONE. On entry to each downstream phase
// it issues a one-cycle start strobe, then waits for that block's done. Every
// phase runs under a watchdog. Empty input skips straight to DONE. A host
// clear aborts the run from any state.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : huffman_phase_ctrl_if.master carrying:
//            go, clear, count_done, count_size, tree/code/enc_done (in)
//            count_en, tree/code/enc_start, busy, done, empty, err,
//            err_code, state, perf_cycles (out, all registered)
// Build option:
//   HUFF_CTRL_PERF_EN : when defined, adds a saturating 32-bit busy-cycle
//                       counter that is reported on perf_cycles. When it is
//                       not defined, perf_cycles is tied to 0.
module huffman_phase_ctrl #(
    parameter int                   TIMEOUT_W   = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    huffman_phase_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_COUNT  = 3'd1,
        S_TREE   = 3'd2,
        S_CODE   = 3'd3,
        S_ENCODE = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // The watchdog reads 0 in the first cycle of a phase. The phase has used
    // up its TIMEOUT_MAX cycles when the count is about to reach TIMEOUT_MAX.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_MAX - 1'b1;

    state_t               st;
    logic [TIMEOUT_W-1:0] wdog;
    logic                 count_en, tree_start, code_start, enc_start;
    logic                 busy, done, empty, err;
    logic [1:0]           err_code;
    logic                 in_phase, phase_done, wd_exp;

    assign in_phase = (st == S_COUNT) || (st == S_TREE) ||
                      (st == S_CODE)  || (st == S_ENCODE);

    // Only the done input of the current phase matters; all others are ignored.
    always_comb begin
        phase_done = 1'b0;
        case (st)
            S_COUNT:  phase_done = bus.count_done;
            S_TREE:   phase_done = bus.tree_done;
            S_CODE:   phase_done = bus.code_done;
            S_ENCODE: phase_done = bus.enc_done;
            default:  phase_done = 1'b0;
        endcase
    end

    assign wd_exp = in_phase && (wdog >= WD_LAST);

    // Priority inside the run: clear, then phase done, then watchdog expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= S_IDLE;
            wdog       <= '0;
            count_en   <= 1'b0;
            tree_start <= 1'b0;
            code_start <= 1'b0;
            enc_start  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            empty      <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            tree_start <= 1'b0;
            code_start <= 1'b0;
            enc_start  <= 1'b0;
            done       <= 1'b0;
            if (in_phase && (wdog != '1))
                wdog <= wdog + 1'b1;

            if (bus.clear) begin
                // Abort: no strobe and no done this cycle. err_code is kept for
                // the host to read; the next go clears it.
                st       <= S_IDLE;
                wdog     <= '0;
                count_en <= 1'b0;
                busy     <= 1'b0;
                err      <= 1'b0;
            end else if (phase_done) begin
                wdog <= '0;
                case (st)
                    S_COUNT: begin
                        count_en <= 1'b0;
                        if (bus.count_size == 16'd0) begin
                            // Nothing to encode, so skip the downstream phases.
                            st    <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            empty <= 1'b1;
                        end else begin
                            st         <= S_TREE;
                            tree_start <= 1'b1;
                        end
                    end
                    S_TREE: begin
                        st         <= S_CODE;
                        code_start <= 1'b1;
                    end
                    S_CODE: begin
                        st        <= S_ENCODE;
                        enc_start <= 1'b1;
                    end
                    default: begin // S_ENCODE
                        st   <= S_DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                endcase
            end else if (wd_exp) begin
                st       <= S_ERROR;
                wdog     <= '0;
                count_en <= 1'b0;
                busy     <= 1'b0;
                err      <= 1'b1;
                err_code <= (st == S_COUNT) ? 2'd1 :
                            (st == S_TREE)  ? 2'd2 : 2'd3;
            end else begin
                case (st)
                    S_IDLE: begin
                        if (bus.go) begin
                            st       <= S_COUNT;
                            wdog     <= '0;
                            count_en <= 1'b1;
                            busy     <= 1'b1;
                            empty    <= 1'b0;
                            err_code <= 2'd0;
                        end
                    end
                    S_DONE:  st <= S_IDLE;
                    default: ; // phases wait for done; ERROR waits for clear
                endcase
            end
        end
    end

    assign bus.state      = st;
    assign bus.count_en   = count_en;
    assign bus.tree_start = tree_start;
    assign bus.code_start = code_start;
    assign bus.enc_start  = enc_start;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.empty      = empty;
    assign bus.err        = err;
    assign bus.err_code   = err_code;

`ifdef HUFF_CTRL_PERF_EN
    logic [31:0] perf_cnt, perf_cycles;
    logic        run_start, run_end;

    assign run_start = (st == S_IDLE) && bus.go && !bus.clear;
    // This fires in the last busy cycle, the one that moves to DONE or ERROR.
    // The latched value therefore excludes that final cycle.
    assign run_end = !bus.clear &&
                     ((phase_done && ((st == S_ENCODE) ||
                                      ((st == S_COUNT) && (bus.count_size == 16'd0)))) ||
                      (!phase_done && wd_exp));

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cnt    <= 32'd0;
            perf_cycles <= 32'd0;
        end else if (run_start) begin
            perf_cnt    <= 32'd0;
            perf_cycles <= 32'd0;
        end else begin
            if (in_phase && (perf_cnt != 32'hFFFF_FFFF))
                perf_cnt <= perf_cnt + 32'd1;
            if (run_end)
                perf_cycles <= perf_cnt;
        end
    end

    assign bus.perf_cycles = perf_cycles;
`else
    assign bus.perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_huffman_phase_ctrl.sv
// Bench for huffman_phase_ctrl. dut_a uses the default watchdog and covers the
// normal, empty, spurious-input, abort and reset runs from a vector table.
// dut_b has TIMEOUT_MAX=8 and covers the watchdog cases with hand-written
// sequences. Both DUTs share the same input drive.
module tb_huffman_phase_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_COUNT = 3'd1, S_TREE = 3'd2,
                           S_CODE = 3'd3, S_ENC = 3'd4, S_DONE = 3'd5, S_ERR = 3'd6;
    localparam int K_NONE = 0, K_GO = 1, K_CLR = 2, K_CD = 3, K_TD = 4,
                   K_COD = 5, K_ED = 6, K_RST = 7;
`ifdef HUFF_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic        rst, go, clr, cd;
        logic [15:0] csz;
        logic        td, cod, ed;
    } in_t;

    typedef struct packed {
        logic [2:0] st;
        logic       cen, ts, cs, es, bsy, dn, emp, er;
        logic [1:0] ec;
    } out_t;

    typedef struct {
        in_t         i;
        out_t        o;
        logic        pchk;
        logic [31:0] pval;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, go, clear, count_done, tree_done, code_done, enc_done;
    logic [15:0] count_size;

    always #5 clk = ~clk;

    huffman_phase_ctrl_if ifa ();
    huffman_phase_ctrl_if ifb ();

    assign ifa.go = go;          assign ifb.go = go;
    assign ifa.clear = clear;    assign ifb.clear = clear;
    assign ifa.count_done = count_done;  assign ifb.count_done = count_done;
    assign ifa.count_size = count_size;  assign ifb.count_size = count_size;
    assign ifa.tree_done = tree_done;    assign ifb.tree_done = tree_done;
    assign ifa.code_done = code_done;    assign ifb.code_done = code_done;
    assign ifa.enc_done = enc_done;      assign ifb.enc_done = enc_done;

    huffman_phase_ctrl dut_a (.clk(clk), .reset(reset), .bus(ifa.master));
    huffman_phase_ctrl #(.TIMEOUT_MAX(16'd8)) dut_b (.clk(clk), .reset(reset), .bus(ifb.master));

    out_t oa, ob;
    assign oa = {ifa.state, ifa.count_en, ifa.tree_start, ifa.code_start, ifa.enc_start,
                 ifa.busy, ifa.done, ifa.empty, ifa.err, ifa.err_code};
    assign ob = {ifb.state, ifb.count_en, ifb.tree_start, ifb.code_start, ifb.enc_start,
                 ifb.busy, ifb.done, ifb.empty, ifb.err, ifb.err_code};

    int   total = 0;
    int   bad   = 0;
    out_t sb[$];
    vec_t tbl[$];

    function automatic in_t inp(input int k, input logic [15:0] sz = 16'd0);
        in_t r;
        r = '0;
        case (k)
            K_GO:    r.go  = 1'b1;
            K_CLR:   r.clr = 1'b1;
            K_CD:    begin r.cd = 1'b1; r.csz = sz; end
            K_TD:    r.td  = 1'b1;
            K_COD:   r.cod = 1'b1;
            K_ED:    r.ed  = 1'b1;
            K_RST:   r.rst = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    // Expected outputs for a state. count_en, busy and err follow the state.
    function automatic out_t E(input logic [2:0] st, input logic ts = 1'b0,
                               input logic cs = 1'b0, input logic es = 1'b0,
                               input logic dn = 1'b0, input logic emp = 1'b0,
                               input logic [1:0] ec = 2'd0);
        out_t r;
        r.st  = st;
        r.cen = (st == S_COUNT);
        r.ts  = ts;
        r.cs  = cs;
        r.es  = es;
        r.bsy = (st >= S_COUNT) && (st <= S_ENC);
        r.dn  = dn;
        r.emp = emp;
        r.er  = (st == S_ERR);
        r.ec  = ec;
        return r;
    endfunction

    task automatic add(input in_t i, input out_t o, input logic pchk = 1'b0,
                       input logic [31:0] pval = 32'd0);
        vec_t v;
        v.i = i; v.o = o; v.pchk = pchk; v.pval = pval;
        tbl.push_back(v);
    endtask

    // One clock: drive inputs, queue the expected outputs, and compare just after the edge.
    task automatic step(input in_t i, input out_t o, input logic sel, input string tag);
        out_t want, got;
        reset = i.rst; go = i.go; clear = i.clr; count_done = i.cd;
        count_size = i.csz; tree_done = i.td; code_done = i.cod; enc_done = i.ed;
        sb.push_back(o);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        got  = sel ? ob : oa;
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b (st,cen,ts,cs,es,busy,done,empty,err,ec)",
                     tag, got, want);
        end
    endtask

    task automatic chk_perf(input logic [31:0] want, input string tag);
        total++;
        if (ifa.perf_cycles !== want) begin
            bad++;
            $display("FAIL %s perf_cycles got=%0d want=%0d", tag, ifa.perf_cycles, want);
        end
    endtask

    initial begin
        in_t x;
        reset = 1'b1; go = 1'b0; clear = 1'b0; count_done = 1'b0; count_size = 16'd0;
        tree_done = 1'b0; code_done = 1'b0; enc_done = 1'b0;

        // ---------------- vector table for dut_a ----------------
        add(inp(K_RST), E(S_IDLE));
        // normal run: count_done 10 cycles after go, then 3-cycle datapath latency
        add(inp(K_GO), E(S_COUNT));
        for (int k = 0; k < 9; k++) add(inp(K_NONE), E(S_COUNT));
        add(inp(K_CD, 16'd40), E(S_TREE, 1));
        for (int k = 0; k < 3; k++) add(inp(K_NONE), E(S_TREE));
        add(inp(K_TD), E(S_CODE, 0, 1));
        for (int k = 0; k < 3; k++) add(inp(K_NONE), E(S_CODE));
        add(inp(K_COD), E(S_ENC, 0, 0, 1));
        for (int k = 0; k < 3; k++) add(inp(K_NONE), E(S_ENC));
        add(inp(K_ED), E(S_DONE, 0, 0, 0, 1));
        add(inp(K_NONE), E(S_IDLE), 1'b1, PERF ? 32'd21 : 32'd0);
        // empty input; reset clears empty
        add(inp(K_GO), E(S_COUNT));
        add(inp(K_CD, 16'd0), E(S_DONE, 0, 0, 0, 1, 1));
        add(inp(K_NONE), E(S_IDLE, 0, 0, 0, 0, 1));
        add(inp(K_NONE), E(S_IDLE, 0, 0, 0, 0, 1));
        add(inp(K_RST), E(S_IDLE));
        // empty again; the next go clears it
        add(inp(K_GO), E(S_COUNT));
        add(inp(K_CD, 16'd0), E(S_DONE, 0, 0, 0, 1, 1));
        add(inp(K_NONE), E(S_IDLE, 0, 0, 0, 0, 1));
        add(inp(K_GO), E(S_COUNT));
        // spurious done/go inputs
        add(inp(K_COD), E(S_COUNT));
        add(inp(K_TD), E(S_COUNT));
        add(inp(K_CD, 16'd3), E(S_TREE, 1));
        add(inp(K_GO), E(S_TREE));
        add(inp(K_ED), E(S_TREE));
        add(inp(K_COD), E(S_TREE));
        add(inp(K_TD), E(S_CODE, 0, 1));
        // abort during CODE
        add(inp(K_NONE), E(S_CODE));
        add(inp(K_CLR), E(S_IDLE));
        add(inp(K_ED), E(S_IDLE));
        add(inp(K_NONE), E(S_IDLE));
        // minimum-latency run: done 5 cycles after go
        add(inp(K_GO), E(S_COUNT));
        add(inp(K_CD, 16'd1), E(S_TREE, 1));
        add(inp(K_TD), E(S_CODE, 0, 1));
        add(inp(K_COD), E(S_ENC, 0, 0, 1));
        add(inp(K_ED), E(S_DONE, 0, 0, 0, 1));
        add(inp(K_NONE), E(S_IDLE), 1'b1, PERF ? 32'd3 : 32'd0);
        // clear beats a same-cycle phase done
        add(inp(K_GO), E(S_COUNT));
        add(inp(K_CD, 16'd2), E(S_TREE, 1));
        x = inp(K_TD); x.clr = 1'b1;
        add(x, E(S_IDLE));
        add(inp(K_NONE), E(S_IDLE));
        // reset mid-ENCODE
        add(inp(K_GO), E(S_COUNT));
        add(inp(K_CD, 16'd7), E(S_TREE, 1));
        add(inp(K_TD), E(S_CODE, 0, 1));
        add(inp(K_COD), E(S_ENC, 0, 0, 1));
        add(inp(K_NONE), E(S_ENC));
        add(inp(K_RST), E(S_IDLE));
        add(inp(K_NONE), E(S_IDLE));

        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[n]) begin
            step(tbl[n].i, tbl[n].o, 1'b0, $sformatf("vec%0d", n));
            if (tbl[n].pchk) chk_perf(tbl[n].pval, $sformatf("perf_vec%0d", n));
        end

        // ---------------- watchdog sequences on dut_b (TIMEOUT_MAX=8) ----------------
        step(inp(K_RST), E(S_IDLE), 1'b1, "b_rst");
        // TREE timeout: ERROR 8 cycles after TREE entry
        step(inp(K_GO), E(S_COUNT), 1'b1, "tt_go");
        step(inp(K_CD, 16'd9), E(S_TREE, 1), 1'b1, "tt_tree");
        for (int k = 0; k < 7; k++) step(inp(K_NONE), E(S_TREE), 1'b1, $sformatf("tt_wait%0d", k));
        step(inp(K_NONE), E(S_ERR, 0, 0, 0, 0, 0, 2), 1'b1, "tt_err");
        step(inp(K_GO), E(S_ERR, 0, 0, 0, 0, 0, 2), 1'b1, "tt_hold");
        step(inp(K_CLR), E(S_IDLE, 0, 0, 0, 0, 0, 2), 1'b1, "tt_clear");
        // COUNT timeout
        step(inp(K_GO), E(S_COUNT), 1'b1, "ct_go");
        for (int k = 0; k < 7; k++) step(inp(K_NONE), E(S_COUNT), 1'b1, $sformatf("ct_wait%0d", k));
        step(inp(K_NONE), E(S_ERR, 0, 0, 0, 0, 0, 1), 1'b1, "ct_err");
        step(inp(K_CLR), E(S_IDLE, 0, 0, 0, 0, 0, 1), 1'b1, "ct_clear");
        // tree_done in the expiry cycle wins; then CODE times out
        step(inp(K_GO), E(S_COUNT), 1'b1, "bd_go");
        step(inp(K_CD, 16'd2), E(S_TREE, 1), 1'b1, "bd_tree");
        for (int k = 0; k < 7; k++) step(inp(K_NONE), E(S_TREE), 1'b1, $sformatf("bd_wait%0d", k));
        step(inp(K_TD), E(S_CODE, 0, 1), 1'b1, "bd_edge");
        for (int k = 0; k < 7; k++) step(inp(K_NONE), E(S_CODE), 1'b1, $sformatf("cd_wait%0d", k));
        step(inp(K_NONE), E(S_ERR, 0, 0, 0, 0, 0, 3), 1'b1, "cd_err");
        step(inp(K_CLR), E(S_IDLE, 0, 0, 0, 0, 0, 3), 1'b1, "cd_clear");
        // ENCODE timeout
        step(inp(K_GO), E(S_COUNT), 1'b1, "et_go");
        step(inp(K_CD, 16'd1), E(S_TREE, 1), 1'b1, "et_tree");
        step(inp(K_TD), E(S_CODE, 0, 1), 1'b1, "et_code");
        step(inp(K_COD), E(S_ENC, 0, 0, 1), 1'b1, "et_enc");
        for (int k = 0; k < 7; k++) step(inp(K_NONE), E(S_ENC), 1'b1, $sformatf("et_wait%0d", k));
        step(inp(K_NONE), E(S_ERR, 0, 0, 0, 0, 0, 3), 1'b1, "et_err");
        step(inp(K_CLR), E(S_IDLE, 0, 0, 0, 0, 0, 3), 1'b1, "et_clear");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/huffman_phase_ctrl.md
# huffman_phase_ctrl

Top-level sequencer for the Huffman encoder. Walks the pipeline through its phases in order: AHB symbol counting, tree construction, code-table generation, then encoding. It issues one-cycle start strobes to each datapath block, waits for that block's done, and enforces a per-phase watchdog. It also handles empty input and host abort, and reports status to the host-side register block.

## Interface
Parameters:
- TIMEOUT_W, 16: width of the phase watchdog counter.
- TIMEOUT_MAX, 16'hFFFF: number of cycles a phase may run before it is declared hung.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- go  in  1  host start request; sampled only in IDLE.
- clear  in  1  host abort; also forwarded to the reader.
- count_done  in  1  reader has finished counting (flag_size).
- count_size  in  16  number of symbols counted.
- tree_done  in  1  tree constructor finished.
- code_done  in  1  code-table generator finished.
- enc_done  in  1  encoder finished.
- count_en  out  1  level signal enabling reader accumulation.
- tree_start  out  1  one-cycle strobe.
- code_start  out  1  one-cycle strobe.
- enc_start  out  1  one-cycle strobe.
- busy  out  1  high in any state other than IDLE, DONE or ERROR.
- done  out  1  one-cycle strobe on entering DONE.
- empty  out  1  last run had count_size==0; held until the next go.
- err  out  1  level signal, high in ERROR.
- err_code  out  2  cause of the error: 1=COUNT, 2=TREE, 3=CODE/ENCODE timeout.
- state  out  3  encoded state for debug.
- perf_cycles  out  32  cycles in the last run (see Configuration).

## Operation
States and encodings: IDLE=0, COUNT=1, TREE=2, CODE=3, ENCODE=4, DONE=5, ERROR=6.

Transitions:
- IDLE -> COUNT on go. This clears empty, err_code and the watchdog.
- COUNT -> TREE on count_done with count_size!=0.
- COUNT -> DONE on count_done with count_size==0. In this case empty is set and no downstream strobes are issued.
- TREE -> CODE on tree_done.
- CODE -> ENCODE on code_done.
- ENCODE -> DONE on enc_done.
- DONE -> IDLE unconditionally on the next cycle.
- ERROR holds until clear or reset; clear returns it to IDLE.

Watchdog:
- Reloads to 0 on every state entry.
- Increments in COUNT, TREE, CODE and ENCODE.
- When it reaches TIMEOUT_MAX with no done present, the block moves to ERROR with the matching err_code. CODE and ENCODE both report 3.
- The watchdog saturates; it never wraps.

Output behaviour:
- count_en is high for the whole of COUNT and nowhere else.
- Done inputs are ignored outside their own phase. A stray tree_done seen in COUNT has no effect.
- clear in any state other than IDLE: the next state is IDLE, every strobe is suppressed that cycle, and done is not asserted.
- go while not in IDLE is ignored.

## Timing
- Every output is registered.
- Reset values: state=IDLE and every other output 0.
- go seen at edge N: state=COUNT and count_en=1 from cycle N+1.
- A done input seen at edge N: the next state is entered at N+1, and its start strobe is high during cycle N+1 only.
- done strobe: high during the first cycle of DONE. busy falls in that same cycle.
- Simultaneous events, in priority order: reset > clear > phase done > watchdog timeout. A done arriving in the same cycle the watchdog expires advances the phase normally.
- reset mid-phase: IDLE on the next edge, strobes 0, empty and err cleared.
- Minimum run with zero latency from each datapath block is go, then 5 cycles to done.

## Configuration
- HUFF_CTRL_PERF_EN defined:
  - A 32-bit cycle counter clears on go and increments in every busy cycle.
  - It saturates at 32'hFFFFFFFF.
  - perf_cycles latches the count on entering DONE or ERROR and holds it until the next go.
- HUFF_CTRL_PERF_EN undefined: no counter is instantiated and perf_cycles is tied to 0.

## Test plan
- Normal run: go; count_done with count_size=16'd40 after 10 cycles; tree_done, code_done and enc_done each 3 cycles after their strobe.
  - Required: each strobe is exactly one cycle wide, in order, and done pulses once.
  - With perf enabled, perf_cycles=21.
- Empty input: go, then count_done with count_size=0.
  - Required: DONE is reached without tree_start, code_start or enc_start; empty=1 until the next go.
- Timeout: TIMEOUT_MAX=8; tree_done is never asserted.
  - Required: ERROR 8 cycles after TREE entry, err=1, err_code=2.
  - A later clear returns the block to IDLE with err=0.
- Abort: clear asserted during CODE.
  - Required: IDLE next cycle, enc_start never pulses, done stays 0.
- Boundary: tree_done asserted in the exact cycle the watchdog hits TIMEOUT_MAX.
  - Required: CODE is entered and err stays 0.
- Spurious inputs: code_done pulsed during COUNT, and go pulsed during TREE.
  - Required: no state change and no extra strobes.
- Reset mid-ENCODE: assert reset for one cycle.
  - Required: all outputs 0 and state=0 on the next edge.
